// File: rtl/iobuf_bank.sv
// rtl/iobuf_bank.sv - multi-channel registered IO buffer controller with dead-time sequencing
//
// Drives one 74LVC1T45 (bidirectional) and one 74LVC1G07 (open-drain) buffer
// per channel, plus the FPGA tristate pin. The read-back path is synchronised
// and can optionally be glitch-filtered.
//
// Ports:
//   clk                   system clock, rising edge
//   rst_n                 synchronous reset, active low
//   oe/od/dir/din         per-channel mode request and value to drive
//   dout                  synchronised (and optionally filtered) pin value
//   busy                  channel is sitting in break-before-make dead time
//   bufdir                74LVC1T45 DIR, 1 = FPGA drives the header
//   bufod                 74LVC1G07 input, 1 = Hi-Z, 0 = pull to GND
//   bufdat_tristate_oe    FPGA tristate output enable
//   bufdat_tristate_dout  FPGA tristate output value
//   bufdat_tristate_din   FPGA tristate input value
module iobuf_bank #(
    parameter int CHANNELS    = 8,
    parameter int DEADTIME    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] oe,
    input  logic [CHANNELS-1:0] od,
    input  logic [CHANNELS-1:0] dir,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] bufdir,
    output logic [CHANNELS-1:0] bufod,
    output logic [CHANNELS-1:0] bufdat_tristate_oe,
    output logic [CHANNELS-1:0] bufdat_tristate_dout,
    input  logic [CHANNELS-1:0] bufdat_tristate_din
);

    typedef enum logic [1:0] {
        CL_HIZ = 2'd0,
        CL_PP  = 2'd1,
        CL_OD  = 2'd2
    } cls_t;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_DEAD   = 1'b1
    } state_t;

    localparam logic [7:0] DT_M1 = 8'(DEADTIME - 1);

    cls_t          applied_q [CHANNELS];
    cls_t          applied_d [CHANNELS];
    state_t        state_q   [CHANNELS];
    state_t        state_d   [CHANNELS];
    logic [7:0]    cnt_q     [CHANNELS];
    logic [7:0]    cnt_d     [CHANNELS];
    logic [CHANNELS-1:0] busy_q;
    logic [CHANNELS-1:0] busy_d;
    logic [CHANNELS-1:0] din_q;

    function automatic cls_t req_class(input logic o, input logic d, input logic r);
        if (o && d) begin
            return CL_OD;
        end else if (o && !r) begin
            return CL_PP;
        end
        return CL_HIZ;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                applied_q[i] <= CL_HIZ;
                state_q[i]   <= ST_ACTIVE;
                cnt_q[i]     <= 8'd0;
            end
            busy_q <= '0;
            din_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                applied_q[i] <= applied_d[i];
                state_q[i]   <= state_d[i];
                cnt_q[i]     <= cnt_d[i];
            end
            busy_q <= busy_d;
            din_q  <= din;
        end
    end

    always_comb begin
        cls_t rq;
        rq = CL_HIZ;
        busy_d = busy_q;
        for (int i = 0; i < CHANNELS; i++) begin
            applied_d[i] = applied_q[i];
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            rq = req_class(oe[i], od[i], dir[i]);
            if (state_q[i] == ST_ACTIVE) begin
                if (rq != applied_q[i]) begin
                    if (applied_q[i] == CL_HIZ) begin
                        // Leaving Hi-Z cannot cause contention, so no dead time.
                        applied_d[i] = rq;
                    end else begin
                        // Break first: float the pins, then wait out the dead time.
                        applied_d[i] = CL_HIZ;
                        state_d[i]   = ST_DEAD;
                        cnt_d[i]     = DT_M1;
                        busy_d[i]    = 1'b1;
                    end
                end
            end else begin
                // Requests seen mid-window are not remembered; only the one
                // present on the final cycle is applied.
                if (cnt_q[i] != 8'd0) begin
                    cnt_d[i] = cnt_q[i] - 8'd1;
                end else begin
                    state_d[i]   = ST_ACTIVE;
                    busy_d[i]    = 1'b0;
                    applied_d[i] = rq;
                end
            end
        end
    end

    // Pin decode looks only at registers, so the pins never follow inputs combinationally.
    always_comb begin
        bufdir               = '0;
        bufod                = '1;
        bufdat_tristate_oe   = '0;
        bufdat_tristate_dout = din_q;
        busy                 = busy_q;
        for (int i = 0; i < CHANNELS; i++) begin
            bufdir[i]             = (applied_q[i] == CL_PP);
            bufdat_tristate_oe[i] = (applied_q[i] == CL_PP);
            bufod[i]              = (applied_q[i] == CL_OD) ? din_q[i] : 1'b1;
        end
    end

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bufdat_tristate_din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_LEN == 0) begin : g_nofilt
            assign dout = s;
        end else begin : g_filt
            localparam int CW = $clog2(FILTER_LEN + 1);
            localparam logic [CW-1:0] FL_M1 = CW'(FILTER_LEN - 1);

            logic [CW-1:0]       fcnt_q [CHANNELS];
            logic [CHANNELS-1:0] fout_q;

            // The counter tracks how long s has disagreed with dout; any
            // agreement restarts it, so short pulses never reach dout.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        fcnt_q[i] <= '0;
                    end
                    fout_q <= '0;
                end else begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (s[i] == fout_q[i]) begin
                            fcnt_q[i] <= '0;
                        end else if (fcnt_q[i] == FL_M1) begin
                            fout_q[i] <= s[i];
                            fcnt_q[i] <= '0;
                        end else begin
                            fcnt_q[i] <= fcnt_q[i] + CW'(1);
                        end
                    end
                end
            end

            assign dout = fout_q;
        end
    endgenerate

endmodule

// File: tb/tb_iobuf_bank.sv
// tb/tb_iobuf_bank.sv - self-checking bench for iobuf_bank
module tb_iobuf_bank;

    localparam int CH = 8;
    localparam int DT = 2;
    localparam int SS = 2;
    localparam int FL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [CH-1:0] oe, od, dir, din, tin;
    logic [CH-1:0] dout_a, busy_a, bufdir_a, bufod_a, toe_a, tdout_a;
    logic [CH-1:0] dout_b, busy_b, bufdir_b, bufod_b, toe_b, tdout_b;

    iobuf_bank #(.CHANNELS(CH), .DEADTIME(DT), .SYNC_STAGES(SS), .FILTER_LEN(0)) u_a (
        .clk(clk), .rst_n(rst_n), .oe(oe), .od(od), .dir(dir), .din(din),
        .dout(dout_a), .busy(busy_a), .bufdir(bufdir_a), .bufod(bufod_a),
        .bufdat_tristate_oe(toe_a), .bufdat_tristate_dout(tdout_a),
        .bufdat_tristate_din(tin)
    );

    iobuf_bank #(.CHANNELS(CH), .DEADTIME(DT), .SYNC_STAGES(SS), .FILTER_LEN(FL)) u_b (
        .clk(clk), .rst_n(rst_n), .oe(oe), .od(od), .dir(dir), .din(din),
        .dout(dout_b), .busy(busy_b), .bufdir(bufdir_b), .bufod(bufod_b),
        .bufdat_tristate_oe(toe_b), .bufdat_tristate_dout(tdout_b),
        .bufdat_tristate_din(tin)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = Hi-Z, 1 = push-pull, 2 = open-drain.
    int            m_applied  [CH];
    int            m_hiz_left [CH];
    logic [CH-1:0] m_din_q;
    logic [CH-1:0] hist [$];
    logic [CH-1:0] sq   [$];
    logic [CH-1:0] m_dout_f;

    function automatic int want(input logic o, input logic d, input logic r);
        if (o && d) return 2;
        if (o && !r) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_applied[i]  = 0;
            m_hiz_left[i] = 0;
        end
        m_din_q  = '0;
        m_dout_f = '0;
        hist.delete();
        repeat (SS) hist.push_back('0);
        sq.delete();
        repeat (FL) sq.push_back('0);
    endtask

    task automatic model_edge();
        logic [CH-1:0] s_prev;
        logic [CH-1:0] flip;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                int r;
                r = want(oe[i], od[i], dir[i]);
                if (m_hiz_left[i] > 0) begin
                    m_hiz_left[i]--;
                    if (m_hiz_left[i] == 0) m_applied[i] = r;
                end else if (m_applied[i] != r) begin
                    if (m_applied[i] == 0) begin
                        m_applied[i] = r;
                    end else begin
                        m_applied[i]  = 0;
                        m_hiz_left[i] = DT;
                    end
                end
            end
            m_din_q = din;
            // Filtered output flips once the last FL synchronised samples all disagree with it.
            s_prev = hist[hist.size() - SS];
            sq.push_back(s_prev);
            if (sq.size() > FL) void'(sq.pop_front());
            flip = '1;
            foreach (sq[k]) flip &= (sq[k] ^ m_dout_f);
            m_dout_f ^= flip;
            hist.push_back(tin);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    endtask

    task automatic compare_model();
        logic [CH-1:0] e_dir, e_od, e_busy;
        for (int i = 0; i < CH; i++) begin
            e_dir[i]  = (m_applied[i] == 1);
            e_od[i]   = (m_applied[i] == 2) ? m_din_q[i] : 1'b1;
            e_busy[i] = (m_hiz_left[i] > 0);
        end
        chk("bufdir_a", 32'(bufdir_a), 32'(e_dir));
        chk("bufod_a",  32'(bufod_a),  32'(e_od));
        chk("toe_a",    32'(toe_a),    32'(e_dir));
        chk("tdout_a",  32'(tdout_a),  32'(m_din_q));
        chk("busy_a",   32'(busy_a),   32'(e_busy));
        chk("dout_a",   32'(dout_a),   32'(hist[hist.size() - SS]));
        chk("bufdir_b", 32'(bufdir_b), 32'(e_dir));
        chk("bufod_b",  32'(bufod_b),  32'(e_od));
        chk("busy_b",   32'(busy_b),   32'(e_busy));
        chk("dout_b",   32'(dout_b),   32'(m_dout_f));
        chk("inv_a", 32'(bufdir_a & ~(toe_a & bufod_a)), 32'd0);
        chk("inv_b", 32'(bufdir_b & ~(toe_b & bufod_b)), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    typedef struct packed {
        logic rst_n, oe, od, dir, din;
        logic e_bufdir, e_bufod, e_toe, e_tdout, e_busy;
    } vec_t;

    vec_t tbl [$];

    initial begin
        model_reset();
        rst_n = 1'b0;
        oe = CH'($urandom()); od = CH'($urandom()); dir = CH'($urandom());
        din = CH'($urandom()); tin = CH'($urandom());

        // Reset with arbitrary inputs for 3 cycles.
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_bufdir", 32'(bufdir_a), 32'd0);
            chk("rst_bufod",  32'(bufod_a),  32'(8'hff));
            chk("rst_toe",    32'(toe_a),    32'd0);
            chk("rst_busy",   32'(busy_a),   32'd0);
            chk("rst_dout_b", 32'(dout_b),   32'd0);
        end
        chk("rst_dout_a", 32'(dout_a), 32'd0);

        //              rst oe od dir din | dir od  toe dout busy
        tbl.push_back({1'b0,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0});
        tbl.push_back({1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0});
        tbl.push_back({1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0});
        tbl.push_back({1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b1});
        tbl.push_back({1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1});
        tbl.push_back({1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0});
        tbl.push_back({1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b0});
        tbl.push_back({1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0});
        tbl.push_back({1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1});
        tbl.push_back({1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1});
        tbl.push_back({1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0});
        tbl.push_back({1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0});
        tbl.push_back({1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b1});
        tbl.push_back({1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b1});
        tbl.push_back({1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b1,1'b1,1'b0});
        tbl.push_back({1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b1});
        tbl.push_back({1'b0,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0});
        tbl.push_back({1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0});
        tbl.push_back({1'b1,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b1});
        tbl.push_back({1'b1,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b1});
        tbl.push_back({1'b1,1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b0});

        tin = '0;
        foreach (tbl[r]) begin
            rst_n = tbl[r].rst_n;
            oe    = {7'd0, tbl[r].oe};
            od    = {7'd0, tbl[r].od};
            dir   = {7'd0, tbl[r].dir};
            din   = {7'd0, tbl[r].din};
            step();
            chk($sformatf("tbl%0d_bufdir", r), 32'(bufdir_a[0]), 32'(tbl[r].e_bufdir));
            chk($sformatf("tbl%0d_bufod", r),  32'(bufod_a[0]),  32'(tbl[r].e_bufod));
            chk($sformatf("tbl%0d_toe", r),    32'(toe_a[0]),    32'(tbl[r].e_toe));
            chk($sformatf("tbl%0d_tdout", r),  32'(tdout_a[0]),  32'(tbl[r].e_tdout));
            chk($sformatf("tbl%0d_busy", r),   32'(busy_a[0]),   32'(tbl[r].e_busy));
        end

        // Input synchroniser and filter latency on channel 3.
        rst_n = 1'b1; oe = '0; od = '0; dir = '0; din = '0; tin = '0;
        repeat (8) step();
        tin = 8'h08;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk($sformatf("sync_e%0d", e), 32'(dout_a[3]), (e >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("filt_e%0d", e), 32'(dout_b[3]), (e >= 5) ? 32'd1 : 32'd0);
        end
        tin = '0;
        repeat (8) step();
        chk("filt_fall", 32'(dout_b[3]), 32'd0);

        // 2-cycle pulse must be rejected by the filter.
        tin = 8'h08;
        step();
        step();
        tin = '0;
        for (int e = 0; e < 8; e++) begin
            step();
            chk("pulse_rej", 32'(dout_b[3]), 32'd0);
        end

        // Reset in the middle of filtering.
        tin = 8'h08;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        chk("midrst_dout_b", 32'(dout_b), 32'd0);
        chk("midrst_dout_a", 32'(dout_a), 32'd0);
        rst_n = 1'b1;
        repeat (8) step();

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                oe  = CH'($urandom());
                od  = CH'($urandom());
                dir = CH'($urandom());
            end
            din = CH'($urandom());
            if ($urandom_range(0, 2) == 0) tin = CH'($urandom());
            rst_n = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
